seg_scan_display: RTL and testbench

Parametrised multiplexed 7-segment scan driver for N common-anode digits.
- Latches a packed hex word from the datapath/debug logic into a shadow register only at frame boundaries, so the display never tears.
- Scans digits with a programmable on-time and an inter-digit blanking gap to suppress ghosting.
- Supports per-digit decimal point and per-digit blanking.
- Drives the board anode/segment pins directly.

---
 rtl/seg_scan_display.sv | 173 +++++++++++++++++
 tb/tb_seg_scan_display.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed 7-segment scan driver for N common-anode digits.
// Each digit slot is BLANK_CYC cycles with every anode off, followed by DRIVE_CYC
// cycles driving that digit. New display words are staged in a pending register
// and only reach the shadow register at the start of digit 0, so a frame never
// mixes old and new data.
// Optional feature: define SEG_SCAN_DIM_EN to add a 4-bit 'bright' input that
// PWM-dims each digit during its DRIVE window.
module seg_scan_display #(
  parameter int N_DIGITS  = 8,
  parameter int DRIVE_CYC = 512,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] disp_data,
  input  logic [N_DIGITS-1:0]   dp_mask,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic                  load,
`ifdef SEG_SCAN_DIM_EN
  input  logic [3:0]            bright,
`endif
  output logic [N_DIGITS-1:0]   digit_anode,
  output logic [7:0]            segment,
  output logic                  frame_start
);

  localparam int MAX_CYC = (DRIVE_CYC > BLANK_CYC) ? DRIVE_CYC : BLANK_CYC;
  localparam int CNT_W   = $clog2((MAX_CYC > 2) ? MAX_CYC : 2);
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_e;

  // One complete display word: nibbles, decimal points and blanking flags.
  typedef struct packed {
    logic [4*N_DIGITS-1:0] data;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   blank;
  } disp_t;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  disp_t              shadow_q, shadow_d;
  disp_t              pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic [N_DIGITS-1:0] anode_q, anode_d;
  logic [7:0]         seg_q, seg_d;
  logic               fs_q, fs_d;

  logic  enter_drive;
  logic  boundary;
  logic  lit;
  disp_t in_word;

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  assign in_word = '{data: disp_data, dp: dp_mask, blank: blank_mask};

  // Scan sequencer: slot timing, digit index and counter next-state.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q + CNT_W'(1);
    enter_drive = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if ((BLANK_CYC == 0) || (cnt_q == BLANK_LAST)) begin
          state_d     = ST_DRIVE;
          cnt_d       = '0;
          enter_drive = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          cnt_d = '0;
          // With no gap the next digit's DRIVE starts immediately.
          if (BLANK_CYC == 0) enter_drive = 1'b1;
          else                state_d     = ST_BLANK;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  assign boundary = enter_drive && (idx_d == '0);

  // Anti-tear staging: loads park in pending, shadow moves only at the frame boundary.
  always_comb begin
    shadow_d   = shadow_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (boundary) begin
      if (load)            shadow_d = in_word;
      else if (pend_vld_q) shadow_d = pend_q;
      pend_vld_d = 1'b0;
    end else if (load) begin
      pend_d     = in_word;
      pend_vld_d = 1'b1;
    end
  end

  // Pin values for the next cycle, derived from next state so anode and segment move together.
  always_comb begin
    anode_d = '1;
    seg_d   = 8'hFF;
    fs_d    = boundary;
    lit     = (state_d == ST_DRIVE) && !shadow_d.blank[idx_d];
`ifdef SEG_SCAN_DIM_EN
    lit     = lit && (4'(cnt_d) <= bright);
`endif
    if (lit) begin
      anode_d = ~(N_DIGITS'(1) << idx_d);
      seg_d   = {~shadow_d.dp[idx_d], decode(shadow_d.data[idx_d*4 +: 4])};
    end
  end

  // State, staging and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= ST_BLANK;
      idx_q      <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      anode_q    <= '1;
      seg_q      <= 8'hFF;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      anode_q    <= anode_d;
      seg_q      <= seg_d;
      fs_q       <= fs_d;
    end
  end

  assign digit_anode = anode_q;
  assign segment     = seg_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: two instances (BLANK_CYC=2 and BLANK_CYC=0) share
// the stimulus; a slot-arithmetic reference model predicts every output cycle.
module tb_seg_scan_display;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int BA = 2;
  localparam int BB = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] disp_data = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  blank_mask = '0;
  logic        load = 1'b0;

  logic [3:0] an_a, an_b;
  logic [7:0] seg_a, seg_b;
  logic       fs_a, fs_b;

  always #5 clk = ~clk;

  seg_scan_display #(.N_DIGITS(N), .DRIVE_CYC(D), .BLANK_CYC(BA)) dut_a (
    .clk(clk), .rst(rst), .disp_data(disp_data), .dp_mask(dp_mask),
    .blank_mask(blank_mask), .load(load),
`ifdef SEG_SCAN_DIM_EN
    .bright(4'hF),
`endif
    .digit_anode(an_a), .segment(seg_a), .frame_start(fs_a));

  seg_scan_display #(.N_DIGITS(N), .DRIVE_CYC(D), .BLANK_CYC(BB)) dut_b (
    .clk(clk), .rst(rst), .disp_data(disp_data), .dp_mask(dp_mask),
    .blank_mask(blank_mask), .load(load),
`ifdef SEG_SCAN_DIM_EN
    .bright(4'hF),
`endif
    .digit_anode(an_b), .segment(seg_b), .frame_start(fs_b));

  int errors = 0;
  int checks = 0;

  // Reference model state: edges since the last reset edge, latest load, per-instance shadow.
  logic [6:0]  dec_tab [16];
  int          k = 0;
  logic [23:0] last_load = '0;     // {blank, dp, data}
  int          last_load_k = -1;
  int          prev_fs_k [2];
  logic [23:0] shadow_m [2];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  // Predict one instance's outputs after the current edge and compare.
  task automatic model_check(input int i, input int b, input logic [3:0] an,
                             input logic [7:0] sg, input logic fs);
    int first, s, pos, dig, w;
    logic drv, efs;
    logic [3:0] ea;
    logic [7:0] es;
    logic [23:0] sh;
    ea = 4'hF; es = 8'hFF; efs = 1'b0; drv = 1'b0; dig = 0;
    first = (b > 0) ? b : 1;
    s = b + D;
    if (!rst && k >= first) begin
      pos = (k - first) % (N * s);
      dig = pos / s;
      w   = pos % s;
      drv = (w < D);
      efs = drv && (dig == 0) && (w == 0);
    end
    if (efs) begin
      if (last_load_k > prev_fs_k[i]) shadow_m[i] = last_load;
      prev_fs_k[i] = k;
    end
    sh = shadow_m[i];
    if (drv && !sh[20 + dig]) begin
      ea = ~(4'b0001 << dig);
      es = {~sh[16 + dig], dec_tab[sh[dig*4 +: 4]]};
    end
    check((i == 0) ? "anode_a" : "anode_b", {4'b0, an}, {4'b0, ea});
    check((i == 0) ? "segment_a" : "segment_b", sg, es);
    check((i == 0) ? "frame_start_a" : "frame_start_b", {7'b0, fs}, {7'b0, efs});
  endtask

  // Advance one clock edge, update the model from the inputs seen at that edge, check both DUTs.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) begin
      k = 0;
      last_load_k = -1;
      prev_fs_k[0] = -1; prev_fs_k[1] = -1;
      shadow_m[0] = '0;  shadow_m[1] = '0;
    end else begin
      k++;
      if (load) begin
        last_load   = {blank_mask, dp_mask, disp_data};
        last_load_k = k;
      end
    end
    model_check(0, BA, an_a, seg_a, fs_a);
    model_check(1, BB, an_b, seg_b, fs_b);
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    disp_data = d; dp_mask = dp; blank_mask = bl; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  int frame_a;

  initial begin
    dec_tab[0]  = 7'b1000000; dec_tab[1]  = 7'b1111001;
    dec_tab[2]  = 7'b0100100; dec_tab[3]  = 7'b0110000;
    dec_tab[4]  = 7'b0011001; dec_tab[5]  = 7'b0010010;
    dec_tab[6]  = 7'b0000010; dec_tab[7]  = 7'b1111000;
    dec_tab[8]  = 7'b0000000; dec_tab[9]  = 7'b0010000;
    dec_tab[10] = 7'b0001000; dec_tab[11] = 7'b0000011;
    dec_tab[12] = 7'b1000110; dec_tab[13] = 7'b0100001;
    dec_tab[14] = 7'b0000110; dec_tab[15] = 7'b0001110;
    prev_fs_k[0] = -1; prev_fs_k[1] = -1;
    shadow_m[0] = '0;  shadow_m[1] = '0;

    // Reset held three cycles: everything dark.
    repeat (3) step();
    rst = 1'b0;

    // Load 1234 ahead of the first boundary, then scan more than one frame.
    do_load(16'h1234, 4'b0000, 4'b0000);
    run_to(45);

    // Anti-tear: load ABCD while digit1 of dut_a drives (slot starts at k=52).
    run_to(54);
    do_load(16'hABCD, 4'b0000, 4'b0000);
    run_to(130);

    // Decimal point on digit0, digit3 blanked, zero data.
    do_load(16'h0000, 4'b0001, 4'b1000);
    run_to(220);

    // Load landing exactly on a dut_a frame boundary edge (k = 2 + 40m).
    frame_a = (k - BA) / (N * (BA + D)) + 1;
    run_to(BA + frame_a * N * (BA + D) - 1);
    do_load(16'h5E6F, 4'b1010, 4'b0000);
    run_to(k + 60);

    // Reset in the middle of dut_a digit2 DRIVE; shadow must come back as zeros.
    frame_a = (k - BA) / (N * (BA + D)) + 1;
    run_to(BA + frame_a * N * (BA + D) + 2 * (BA + D) + 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_to(90);

    // Randomised loads, including back-to-back ones within a frame.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(15, 0) == 0) begin
        do_load(16'($urandom()), 4'($urandom()), 4'($urandom_range(15, 0) & 4'($urandom())));
      end else begin
        disp_data = 16'($urandom());
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
